// File: rtl/vc_arbiter.sv
// vc_arbiter: weighted two-VC arbiter feeding a two-stage pipeline that routes each word to one of two destinations
module vc_arbiter #(
  parameter int BW = 6,
  parameter int WEIGHT = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          VC0_empty,
  input  logic          VC1_empty,
  input  logic [BW-1:0] VC0_data_out,
  input  logic [BW-1:0] VC1_data_out,
  input  logic          D0_almost_full,
  input  logic          D1_almost_full,
  output logic          VC0_rd,
  output logic          VC1_rd,
  output logic [BW-1:0] data_out,
  output logic          D0_push,
  output logic          D1_push,
  output logic          idle
);
  logic          stall;
  logic          starve;
  logic          s1_valid;
  logic          s1_src;
  logic [3:0]    cnt;
  logic [BW-1:0] selected_data;
  always_comb begin
    stall = D0_almost_full | D1_almost_full;
    starve = cnt == 4'(WEIGHT);
    VC1_rd = reset_L & !stall & !VC1_empty & (VC0_empty | starve);
    VC0_rd = reset_L & !stall & !VC0_empty & !(starve & !VC1_empty);
    selected_data = s1_src ? VC1_data_out : VC0_data_out;
    idle = VC0_empty & VC1_empty & !s1_valid & !D0_push & !D1_push;
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt <= 4'd0;
      s1_valid <= 1'b0;
      s1_src <= 1'b0;
      data_out <= '0;
      D0_push <= 1'b0;
      D1_push <= 1'b0;
    end else begin
      cnt <= VC1_rd ? 4'd0 :
             (VC0_rd & !VC1_empty) ? cnt + 4'd1 :
             (VC1_empty & !VC0_rd) ? 4'd0 : cnt;
      s1_valid <= VC0_rd | VC1_rd;
      s1_src <= VC1_rd;
      data_out <= s1_valid ? selected_data : data_out;
      D0_push <= s1_valid & !selected_data[BW-1];
      D1_push <= s1_valid & selected_data[BW-1];
    end
  end
endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: randomized and directed checks of vc_arbiter against a queue-based reference model
module tb_vc_arbiter;
  localparam int BW = 6;
  localparam int WEIGHT = 4;
  logic clk = 0;
  logic reset_L = 0;
  logic VC0_empty = 1, VC1_empty = 1;
  logic D0_almost_full = 0, D1_almost_full = 0;
  logic [BW-1:0] VC0_data_out = '0, VC1_data_out = '0;
  logic VC0_rd, VC1_rd, D0_push, D1_push, idle;
  logic [BW-1:0] data_out;

  always #5 clk = ~clk;

  vc_arbiter #(.BW(BW), .WEIGHT(WEIGHT)) dut (
    .clk(clk), .reset_L(reset_L), .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
    .VC0_data_out(VC0_data_out), .VC1_data_out(VC1_data_out),
    .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
    .VC0_rd(VC0_rd), .VC1_rd(VC1_rd), .data_out(data_out),
    .D0_push(D0_push), .D1_push(D1_push), .idle(idle)
  );

  typedef struct {int due; logic [BW-1:0] w;} item_t;
  logic [BW-1:0] q0[$], q1[$];
  item_t pend[$];
  int cyc = 0, streak = 0, checks = 0, errors = 0;
  logic exp_rd0 = 0, exp_rd1 = 0, exp_p0 = 0, exp_p1 = 0, exp_idle = 1;
  logic [BW-1:0] exp_dout = '0;

  // Refresh FIFO flags, move to mid-cycle and predict this cycle's grants from the arbitration rules.
  task automatic settle();
    VC0_empty = q0.size() == 0;
    VC1_empty = q1.size() == 0;
    @(negedge clk);
    if (!reset_L) begin
      pend.delete();
      streak = 0;
      exp_p0 = 0;
      exp_p1 = 0;
      exp_dout = '0;
    end
    exp_rd1 = reset_L && !(D0_almost_full || D1_almost_full) && q1.size() > 0 &&
              (q0.size() == 0 || streak == WEIGHT);
    exp_rd0 = reset_L && !(D0_almost_full || D1_almost_full) && q0.size() > 0 && !exp_rd1;
    exp_idle = q0.size() == 0 && q1.size() == 0 && pend.size() == 0 && !exp_p0 && !exp_p1;
  endtask

  // Commit predicted grants to the scoreboard, cross the clock edge and model the FIFOs' read latency.
  task automatic tick();
    logic r0, r1;
    item_t it;
    r0 = VC0_rd;
    r1 = VC1_rd;
    if (exp_rd0) begin it.due = cyc + 2; it.w = q0[0]; pend.push_back(it); end
    if (exp_rd1) begin it.due = cyc + 2; it.w = q1[0]; pend.push_back(it); end
    streak = exp_rd1 ? 0 : (exp_rd0 && q1.size() > 0) ? streak + 1 :
             (q1.size() == 0 && !exp_rd0) ? 0 : streak;
    @(posedge clk);
    #1;
    cyc++;
    if (r0 && q0.size() > 0) VC0_data_out = q0.pop_front();
    if (r1 && q1.size() > 0) VC1_data_out = q1.pop_front();
    exp_p0 = 0;
    exp_p1 = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      it = pend.pop_front();
      exp_p0 = !it.w[BW-1];
      exp_p1 = it.w[BW-1];
      exp_dout = it.w;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && (q0.size() > 0 || q1.size() > 0 || pend.size() > 0); i++) begin
      tick();
      settle();
      checks++;
      if ({VC0_rd, VC1_rd, D0_push, D1_push, data_out} !== {exp_rd0, exp_rd1, exp_p0, exp_p1, exp_dout}) begin
        errors++;
        $display("FAIL %s_drain cyc=%0d got=%b exp=%b", tag, cyc,
                 {VC0_rd, VC1_rd, D0_push, D1_push, data_out}, {exp_rd0, exp_rd1, exp_p0, exp_p1, exp_dout});
      end
    end
    tick();
    settle();
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle cyc=%0d got=%b exp=1", tag, cyc, idle);
    end
  endtask

  task automatic test_reset();
    reset_L = 0;
    for (int i = 0; i < 3; i++) begin
      q0.push_back(BW'($urandom));
      q1.push_back(BW'($urandom));
    end
    settle();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({VC0_rd, VC1_rd, D0_push, D1_push, data_out, idle} !== {4'b0000, {BW{1'b0}}, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc,
                 {VC0_rd, VC1_rd, D0_push, D1_push, data_out, idle}, {4'b0000, {BW{1'b0}}, 1'b0});
      end
      tick();
      settle();
    end
    tick();
    reset_L = 1;
    settle();
    checks++;
    if ({VC0_rd, VC1_rd} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_read cyc=%0d got=%b exp=10", cyc, {VC0_rd, VC1_rd});
    end
    drain("reset");
  endtask

  task automatic test_priority();
    logic [BW-1:0] w[3];
    for (int i = 0; i < 3; i++) begin
      w[i] = BW'($urandom) & {1'b0, {(BW-1){1'b1}}};
      q0.push_back(w[i]);
    end
    for (int c = 0; c < 7; c++) begin
      tick();
      settle();
      checks++;
      if ({VC0_rd, VC1_rd, D0_push, D1_push, data_out, idle} !== {exp_rd0, exp_rd1, exp_p0, exp_p1, exp_dout, exp_idle}) begin
        errors++;
        $display("FAIL priority_model cyc=%0d got=%b exp=%b", cyc,
                 {VC0_rd, VC1_rd, D0_push, D1_push, data_out, idle}, {exp_rd0, exp_rd1, exp_p0, exp_p1, exp_dout, exp_idle});
      end
      checks++;
      if ({VC0_rd, D0_push, D1_push} !== {c <= 2, c >= 2 && c <= 4, 1'b0}) begin
        errors++;
        $display("FAIL priority_timing c=%0d got=%b exp=%b", c, {VC0_rd, D0_push, D1_push}, {c <= 2, c >= 2 && c <= 4, 1'b0});
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (data_out !== w[c-2]) begin
          errors++;
          $display("FAIL priority_data c=%0d got=%h exp=%h", c, data_out, w[c-2]);
        end
      end
    end
    drain("priority");
  endtask

  task automatic test_weighting();
    int n1 = 0;
    for (int i = 0; i < 24; i++) begin
      q0.push_back(BW'($urandom));
      q1.push_back(BW'($urandom));
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      settle();
      checks++;
      if ({VC0_rd, VC1_rd, D0_push, D1_push, data_out} !== {exp_rd0, exp_rd1, exp_p0, exp_p1, exp_dout}) begin
        errors++;
        $display("FAIL weighting_model cyc=%0d got=%b exp=%b", cyc,
                 {VC0_rd, VC1_rd, D0_push, D1_push, data_out}, {exp_rd0, exp_rd1, exp_p0, exp_p1, exp_dout});
      end
      checks++;
      if ({VC0_rd, VC1_rd} !== ((c % (WEIGHT + 1) == WEIGHT) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL weighting_pattern c=%0d got=%b exp=%b", c, {VC0_rd, VC1_rd},
                 (c % (WEIGHT + 1) == WEIGHT) ? 2'b01 : 2'b10);
      end
      n1 += int'(VC1_rd);
    end
    checks++;
    if (n1 != 2) begin
      errors++;
      $display("FAIL weighting_share got=%0d exp=2", n1);
    end
    drain("weighting");
  endtask

  task automatic test_routing();
    q1.push_back(6'b100101);
    for (int c = 0; c < 4; c++) begin
      tick();
      settle();
      checks++;
      if ({VC0_rd, VC1_rd, D0_push, D1_push, data_out} !== {exp_rd0, exp_rd1, exp_p0, exp_p1, exp_dout}) begin
        errors++;
        $display("FAIL routing_model cyc=%0d got=%b exp=%b", cyc,
                 {VC0_rd, VC1_rd, D0_push, D1_push, data_out}, {exp_rd0, exp_rd1, exp_p0, exp_p1, exp_dout});
      end
      if (c == 2) begin
        checks++;
        if ({D0_push, D1_push, data_out} !== {2'b01, 6'b100101}) begin
          errors++;
          $display("FAIL routing_d1 got=%b exp=%b", {D0_push, D1_push, data_out}, {2'b01, 6'b100101});
        end
      end
    end
    drain("routing");
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) q0.push_back(BW'($urandom));
    for (int c = 0; c < 12; c++) begin
      tick();
      D1_almost_full = c >= 5 && c <= 8;
      settle();
      checks++;
      if ({VC0_rd, VC1_rd, D0_push, D1_push, data_out} !== {exp_rd0, exp_rd1, exp_p0, exp_p1, exp_dout}) begin
        errors++;
        $display("FAIL backpressure_model cyc=%0d got=%b exp=%b", cyc,
                 {VC0_rd, VC1_rd, D0_push, D1_push, data_out}, {exp_rd0, exp_rd1, exp_p0, exp_p1, exp_dout});
      end
      if (c >= 5 && c <= 10) begin
        checks++;
        if ({VC0_rd, D0_push | D1_push} !== {c >= 9, c <= 6}) begin
          errors++;
          $display("FAIL backpressure_timing c=%0d got=%b exp=%b", c, {VC0_rd, D0_push | D1_push}, {c >= 9, c <= 6});
        end
      end
    end
    drain("backpressure");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(BW'($urandom));
      q1.push_back(BW'($urandom));
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      reset_L = c != 3;
      settle();
      checks++;
      if ({VC0_rd, VC1_rd, D0_push, D1_push, data_out} !== {exp_rd0, exp_rd1, exp_p0, exp_p1, exp_dout}) begin
        errors++;
        $display("FAIL reset_mid_model cyc=%0d got=%b exp=%b", cyc,
                 {VC0_rd, VC1_rd, D0_push, D1_push, data_out}, {exp_rd0, exp_rd1, exp_p0, exp_p1, exp_dout});
      end
      if (c >= 3 && c <= 8) begin
        checks++;
        if ({VC0_rd, VC1_rd, D0_push | D1_push} !== {c >= 4 && c <= 7, c == 8, c >= 6}) begin
          errors++;
          $display("FAIL reset_mid_window c=%0d got=%b exp=%b", c, {VC0_rd, VC1_rd, D0_push | D1_push},
                   {c >= 4 && c <= 7, c == 8, c >= 6});
        end
      end
    end
    drain("reset_mid");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick();
      if (q0.size() < 8 && $urandom_range(0, 2) == 0) q0.push_back(BW'($urandom));
      if (q1.size() < 8 && $urandom_range(0, 2) == 0) q1.push_back(BW'($urandom));
      D0_almost_full = $urandom_range(0, 9) == 0;
      D1_almost_full = $urandom_range(0, 9) == 0;
      reset_L = $urandom_range(0, 99) != 0;
      settle();
      checks++;
      if ({VC0_rd, VC1_rd, D0_push, D1_push, data_out, idle} !== {exp_rd0, exp_rd1, exp_p0, exp_p1, exp_dout, exp_idle}) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc,
                 {VC0_rd, VC1_rd, D0_push, D1_push, data_out, idle}, {exp_rd0, exp_rd1, exp_p0, exp_p1, exp_dout, exp_idle});
      end
    end
    D0_almost_full = 0;
    D1_almost_full = 0;
    reset_L = 1;
    drain("random");
  endtask

  initial begin
    test_reset();
    test_priority();
    test_weighting();
    test_routing();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 Parameter BW, default 6: data width in bits; bit BW-1 of each word is the destination select.
REQ-002 Parameter WEIGHT, default 4: maximum consecutive VC0 grants while VC1 is waiting; legal range 1..15.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset_L, input, 1: asynchronous, active-low reset.
REQ-005 Port VC0_empty, input, 1: VC0 FIFO is empty.
REQ-006 Port VC1_empty, input, 1: VC1 FIFO is empty.
REQ-007 Port VC0_data_out, input, BW: VC0 FIFO read data, valid the cycle after VC0_rd.
REQ-008 Port VC1_data_out, input, BW: VC1 FIFO read data, valid the cycle after VC1_rd.
REQ-009 Port D0_almost_full, input, 1: destination 0 FIFO is almost full.
REQ-010 Port D1_almost_full, input, 1: destination 1 FIFO is almost full.
REQ-011 Port VC0_rd, output, 1: pop VC0 this cycle.
REQ-012 Port VC1_rd, output, 1: pop VC1 this cycle.
REQ-013 Port data_out, output, BW: registered word forwarded to a destination.
REQ-014 Port D0_push, output, 1: write data_out into destination 0.
REQ-015 Port D1_push, output, 1: write data_out into destination 1.
REQ-016 Port idle, output, 1: both VCs are empty and no word is in flight.

Function
REQ-017 stall = D0_almost_full OR D1_almost_full; reads are combinational from the current inputs and state.
REQ-018 VC0_rd = !stall AND !VC0_empty AND !(starve AND !VC1_empty).
REQ-019 VC1_rd = !stall AND !VC1_empty AND (VC0_empty OR starve).
REQ-020 VC0_rd and VC1_rd are never high in the same cycle.
REQ-021 Counter cnt (4 bits) increments on each VC0_rd while VC1_empty=0.
REQ-022 cnt clears on any VC1_rd, and whenever VC1_empty=1 with no VC0_rd that cycle.
REQ-023 starve = (cnt == WEIGHT).
REQ-024 Consequence of REQ-018..023: with both VCs non-empty, the grant sequence is WEIGHT VC0 reads, then one VC1 read, repeating.
REQ-025 Stage 1 register s1_valid <= VC0_rd|VC1_rd.
REQ-026 Stage 1 register s1_src <= VC1_rd.
REQ-027 Stage 2 (output) register: data_out <= s1_src ? VC1_data_out : VC0_data_out when s1_valid, else holds its value.
REQ-028 D0_push <= s1_valid AND !selected_data[BW-1].
REQ-029 D1_push <= s1_valid AND selected_data[BW-1].
REQ-030 Latency: rd asserted in cycle N gives a push in cycle N+2; throughput is one word per cycle.
REQ-031 Stall does not flush the pipeline; up to 2 words in flight complete after stall rises, so the destination almost_full thresholds reserve >= 2 entries.
REQ-032 idle = VC0_empty AND VC1_empty AND !s1_valid AND !D0_push AND !D1_push.
REQ-033 D0_push and D1_push are never both high.
REQ-034 A push is single-cycle per word; no word is duplicated or dropped.

Reset
REQ-035 While reset_L=0, the following hold asynchronously: cnt=0, s1_valid=0, s1_src=0, data_out=0, D0_push=0, D1_push=0.
REQ-036 While reset_L=0, VC0_rd=0 and VC1_rd=0 regardless of the other inputs.
REQ-037 Reset asserted mid-transfer discards words in flight without pushing them.
REQ-038 The first read after reset deassertion can occur in the first clock cycle in which reset_L=1.

Verification
REQ-039 Reset: reset_L=0 with both VCs non-empty -> VC0_rd=VC1_rd=0, pushes=0, data_out=0.
REQ-040 Priority: VC0 holds 3 words (data[5]=0), VC1 empty -> VC0_rd in cycles 0-2; D0_push in cycles 2-4 with matching data.
REQ-041 Weighting: both VCs always non-empty, WEIGHT=4 -> rd pattern 0,0,0,0,1,0,0,0,0,1; VC1 receives exactly 2 of 10 grants.
REQ-042 Routing: VC1 word 6'b100101 -> D1_push=1, data_out=6'b100101, D0_push=0 at N+2.
REQ-043 Backpressure: D1_almost_full rises at cycle 5 during streaming -> no rd from cycle 5; the 2 in-flight words are pushed in cycles 5-6; reads resume the cycle after it falls.
REQ-044 Reset mid-operation: reset_L pulsed low while s1_valid=1 -> no push follows; cnt=0; the next grant starts a fresh weighting window.
